// File: rtl/note_lane_renderer.sv
// Single-lane note box renderer: on each frame tick, erases the previous box and draws the new one.
// Optional compile-time macro NOTE_OUTLINE_EN draws only the box outline (interior in BG_COLOUR).
module note_lane_renderer #(
  parameter int          X_POS       = 40,
  parameter int          BOX_W       = 8,
  parameter int          BOX_H       = 4,
  parameter int          SCREEN_H    = 120,
  parameter logic [2:0]  NOTE_COLOUR = 3'b110,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] y_in,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StErase  = 2'd1;
  localparam logic [1:0] StDraw   = 2'd2;
  localparam logic [1:0] StFinish = 2'd3;

  localparam logic [7:0] NoNote = 8'hFF;

  logic [1:0] state_q, state_d;
  logic [7:0] prev_y_q, prev_y_d;
  logic [7:0] new_y_q, new_y_d;
  logic [3:0] dx_q, dx_d;
  logic [3:0] dy_q, dy_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] base;
  logic [8:0] row;
  logic       last_dx;
  logic       last_dy;
  logic       border;
  logic [2:0] draw_colour;

  assign base    = (state_q == StDraw) ? new_y_q : prev_y_q;
  assign row     = {1'b0, base} + {5'd0, dy_q};
  assign last_dx = (dx_q == 4'(BOX_W - 1));
  assign last_dy = (dy_q == 4'(BOX_H - 1));
  assign border  = (dx_q == 4'd0) || last_dx || (dy_q == 4'd0) || last_dy;

`ifdef NOTE_OUTLINE_EN
  assign draw_colour = border ? NOTE_COLOUR : BG_COLOUR;
`else
  assign draw_colour = NOTE_COLOUR;
`endif

  always_comb begin
    state_d  = state_q;
    prev_y_d = prev_y_q;
    new_y_d  = new_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    vga_x_d  = vga_x_q;
    vga_y_d  = vga_y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          new_y_d = y_in;
          dx_d    = 4'd0;
          dy_d    = 4'd0;
          state_d = StErase;
        end
      end

      StErase, StDraw: begin
        vga_x_d  = 8'(X_POS) + {4'd0, dx_q};
        vga_y_d  = row[6:0];
        colour_d = (state_q == StDraw) ? draw_colour : BG_COLOUR;
        // Clipped or absent pixels still consume their slot so update length is fixed.
        plot_d   = (base != NoNote) && (row < 9'(SCREEN_H));
        busy_d   = 1'b1;
        if (last_dx) begin
          dx_d = 4'd0;
          if (last_dy) begin
            dy_d    = 4'd0;
            state_d = (state_q == StErase) ? StDraw : StFinish;
          end else begin
            dy_d = dy_q + 4'd1;
          end
        end else begin
          dx_d = dx_q + 4'd1;
        end
      end

      StFinish: begin
        // Stay here through the done cycle so a start coincident with done is dropped.
        if (!done_q) begin
          done_d   = 1'b1;
          prev_y_d = new_y_q;
        end else begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      prev_y_q <= NoNote;
      new_y_q  <= NoNote;
      dx_q     <= 4'd0;
      dy_q     <= 4'd0;
      vga_x_q  <= 8'd0;
      vga_y_q  <= 7'd0;
      colour_q <= 3'd0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_y_q <= prev_y_d;
      new_y_q  <= new_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      vga_x_q  <= vga_x_d;
      vga_y_q  <= vga_y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign vga_x  = vga_x_q;
  assign vga_y  = vga_y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_note_lane_renderer.sv
// Self-checking bench for note_lane_renderer with default parameters; model honours NOTE_OUTLINE_EN.
module tb_note_lane_renderer;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] y_in = 8'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  int prev_m = 255;

  note_lane_renderer dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .y_in   (y_in),
    .vga_x  (vga_x),
    .vga_y  (vga_y),
    .colour (colour),
    .plot   (plot),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // One full update: start accepted at edge k, every cycle up to k+2N+2 compared with the model.
  task automatic test_frame(input int y, input bit poke_mid, input bit poke_done);
    logic [20:0] got;
    logic [20:0] exp;
    int idx, dx, dy, base, row, ec, ep;
    start = 1'b1;
    y_in  = y[7:0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      start = (poke_mid && i == 9) ? 1'b1 : 1'b0;
      y_in  = 8'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      idx  = i % N;
      dx   = idx % W;
      dy   = idx / W;
      base = (i < N) ? prev_m : y;
      row  = base + dy;
      ep   = (base != 255 && row < 120) ? 1 : 0;
      if (i < N) ec = 0;
      else begin
`ifdef NOTE_OUTLINE_EN
        ec = (dx == 0 || dx == W - 1 || dy == 0 || dy == H - 1) ? 6 : 0;
`else
        ec = 6;
`endif
      end
      got = {vga_x, vga_y, colour, plot, busy, done};
      exp = {8'(40 + dx), 7'(row % 128), 3'(ec), 1'(ep), 1'b1, 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL pixel y=%0d slot=%0d got {x,y,c,plot,busy,done}=%h required %h",
                 y, i, got, exp);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if ({plot, busy, done} !== 3'b001) begin
      miscompares++;
      $display("FAIL done_pulse y=%0d got {plot,busy,done}=%b required 001", y, {plot, busy, done});
    end
    if (poke_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if ({plot, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL done_end y=%0d got {plot,busy,done}=%b required 000", y, {plot, busy, done});
    end
    prev_m = y;
    if (poke_done) begin
      @(posedge clk); #1;
      vectors++;
      if ({plot, busy, done} !== 3'b000) begin
        miscompares++;
        $display("FAIL start_on_done got {plot,busy,done}=%b required 000", {plot, busy, done});
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #3;
    vectors++;
    if ({vga_x, vga_y, colour, plot, busy, done} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h required 0", {vga_x, vga_y, colour, plot, busy, done});
    end
    @(negedge clk);
    resetn = 1'b1;
    prev_m = 255;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({plot, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_after_reset got %b required 000", {plot, busy, done});
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    y_in  = 8'd50;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    vectors++;
    if ({plot, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL mid_update_active got {plot,busy}=%b required 11", {plot, busy});
    end
    resetn = 1'b0;
    #1;
    vectors++;
    if ({vga_x, vga_y, colour, plot, busy, done} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_mid got %h required 0", {vga_x, vga_y, colour, plot, busy, done});
    end
    @(negedge clk);
    resetn = 1'b1;
    prev_m = 255;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({plot, busy, done} !== 3'b000) begin
        miscompares++;
        $display("FAIL no_partial_done cycle=%0d got %b required 000", i, {plot, busy, done});
      end
    end
    test_frame(60, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    int y;
    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 3))
        0:       y = 255;
        1:       y = $urandom_range(110, 127);
        default: y = $urandom_range(0, 254);
      endcase
      test_frame(y, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_frame(10, 1'b0, 1'b0);
    test_frame(20, 1'b0, 1'b0);
    test_frame(118, 1'b0, 1'b0);
    test_frame(20, 1'b0, 1'b0);
    test_frame(255, 1'b0, 1'b0);
    test_frame(30, 1'b1, 1'b1);
    test_frame(31, 1'b0, 1'b0);
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/note_lane_renderer.md
# note_lane_renderer

Downstream consumer of the double-buffered note-position stream: on each frame tick it captures the 8-bit note row (`y_in`), erases the note box drawn on the previous frame, and draws the box at the new row, emitting one pixel per clock to the VGA adapter's plot port. One instance serves one lane; the lane's horizontal position is a parameter.

## Interface
Parameters:
- `X_POS`, 40: left pixel column of the lane (0..159).
- `BOX_W`, 8: box width in pixels (1..16).
- `BOX_H`, 4: box height in pixels (1..16).
- `SCREEN_H`, 120: visible rows; rows >= SCREEN_H are clipped.
- `NOTE_COLOUR`, 3'b110: box colour.
- `BG_COLOUR`, 3'b000: erase colour.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame tick, single-cycle pulse.
- `y_in`  in  8  note top row; 8'hFF = no note in lane.
- `vga_x`  out  8  pixel column.
- `vga_y`  out  7  pixel row.
- `colour`  out  3  pixel colour.
- `plot`  out  1  pixel write strobe.
- `busy`  out  1  high while erasing or drawing.
- `done`  out  1  one-cycle pulse at end of frame update.

## Operation
- FSM states: IDLE, ERASE, DRAW, FINISH.
- IDLE: on `start`=1, capture `y_in` into `new_y`, clear counters, go to ERASE. `start` is ignored in every other state; it is not queued.
- ERASE: walk BOX_W*BOX_H pixels, row-major (`dx` fastest), at row base `prev_y`, colour BG_COLOUR. After the last pixel, go to DRAW.
- DRAW: same walk at row base `new_y`, colour NOTE_COLOUR. After the last pixel, go to FINISH.
- FINISH: pulse `done`, copy `new_y` into `prev_y`, return to IDLE.
- Pixel address:
  - `vga_x` = X_POS + `dx`.
  - `vga_y` = base + `dy`, computed 9 bits wide and truncated to 7 bits for output.
- `plot` = 1 only for in-range pixels:
  - Suppressed when base == 8'hFF (no note).
  - Suppressed when base + `dy` >= SCREEN_H (clipped). The pixel slot still consumes its cycle.
- Cycle count per update is constant regardless of `y_in`, so frame budgeting is deterministic.
- `prev_y` resets to 8'hFF, so the first update after reset emits no erase plots.

## Timing
- Reset values (asynchronous): state IDLE, `prev_y` = `new_y` = 8'hFF, counters 0; `vga_x`, `vga_y`, `colour`, `plot`, `busy`, `done` all 0.
- All outputs are registered. With `start` sampled at edge k:
  - Erase pixels are presented after edges k+1 .. k+N, where N = BOX_W*BOX_H.
  - Draw pixels are presented after edges k+N+1 .. k+2N.
  - `done` is high for exactly the cycle after edge k+2N+1.
  - `busy` is high from k+1 through k+2N.
- `start` coincident with `done` is ignored, since the FSM is not yet in IDLE. Earliest accepted `start` is the cycle after `done`.
- `y_in` is sampled only at the accepting edge. Changes during an update have no effect.
- Reset mid-update: outputs drop to 0 at once, with no partial `done`. The next update behaves as the first after reset, so stale pixels on screen are not erased.

## Configuration
- `NOTE_OUTLINE_EN`:
  - Defined: in DRAW, only border pixels (`dx`==0, `dx`==BOX_W-1, `dy`==0, `dy`==BOX_H-1) use NOTE_COLOUR. Interior pixels are plotted in BG_COLOUR. Cycle count and plot strobes are unchanged.
  - Undefined: DRAW fills the whole box in NOTE_COLOUR.

## Test plan
- After reset, `start` with `y_in`=10: 32 erase cycles with `plot`=0; then 32 draw cycles with `plot`=1, x 40..47, y 10..13, colour 3'b110; `done` at k+65.
- Second `start` with `y_in`=20: 32 erase plots at y 10..13 with colour 3'b000, then draw at y 20..23.
- `y_in`=118: rows 118..119 plotted, rows 120..121 have `plot`=0; `done` still at k+65.
- `y_in`=8'hFF after a note at 20: erase at y 20..23, zero draw plots, `prev_y` becomes 8'hFF.
- `start` pulsed at k+10 and on the `done` cycle: both ignored, no extra `done`. Reset at k+40: all outputs 0 immediately, next update has no erase plots.
- `NOTE_OUTLINE_EN` defined, `y_in`=10: pixel (41,11) gets colour 3'b000 with `plot`=1; pixel (40,11) gets colour 3'b110.
